// File: rtl/cpu_pkg.sv
// Shared CPU constants: datapath widths and branch condition codes.
package cpu_pkg;
  localparam int XLEN = 32;
  localparam int RD_W = 5;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;
endpackage

// File: rtl/branch_cond.sv
// Branch condition evaluation from ALU flags; purely combinational.
module branch_cond
  import cpu_pkg::*;
(
  input  logic [2:0] funct3,
  input  logic       n,
  input  logic       z,
  input  logic       c,
  input  logic       v,
  output logic       cond
);

  // c=1 means no borrow, so unsigned a<b is !c
  always_comb begin
    cond = 1'b0;
    case (funct3)
      F3_BEQ:  cond = z;
      F3_BNE:  cond = ~z;
      F3_BLT:  cond = n ^ v;
      F3_BGE:  cond = ~(n ^ v);
      F3_BLTU: cond = ~c;
      F3_BGEU: cond = c;
      default: cond = 1'b0;
    endcase
  end

endmodule

// File: rtl/ex_mem_reg.sv
// EX/MEM pipeline register with branch resolution, bubble insertion and a
// taken-branch counter.
module ex_mem_reg
  import cpu_pkg::*;
#(
  parameter int XLEN = cpu_pkg::XLEN,
  parameter int RD_W = cpu_pkg::RD_W
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            stall,
  input  logic            flush,
  input  logic            valid_in,
  input  logic [XLEN-1:0] alu_out,
  input  logic            z,
  input  logic            c,
  input  logic            v,
  input  logic [XLEN-1:0] rs2_data,
  input  logic [RD_W-1:0] rd,
  input  logic [2:0]      funct3,
  input  logic            is_branch,
  input  logic            reg_write,
  input  logic            mem_read,
  input  logic            mem_write,
  input  logic            mem_to_reg,
  input  logic [XLEN-1:0] pc_target,
  output logic            m_valid,
  output logic            m_reg_write,
  output logic            m_mem_read,
  output logic            m_mem_write,
  output logic            m_mem_to_reg,
  output logic [XLEN-1:0] m_alu_out,
  output logic [XLEN-1:0] m_rs2_data,
  output logic [XLEN-1:0] m_branch_target,
  output logic [RD_W-1:0] m_rd,
  output logic            m_branch_taken,
  output logic [31:0]     taken_count
);

  logic        cond;
  logic        take;
  logic [31:0] count_cur;

  branch_cond u_branch_cond (
    .funct3 (funct3),
    .n      (alu_out[XLEN-1]),
    .z      (z),
    .c      (c),
    .v      (v),
    .cond   (cond)
  );

  assign take      = is_branch & valid_in & cond;
  assign count_cur = taken_count;

  always_ff @(posedge clk) begin
    if (rst) begin
      m_valid         <= 1'b0;
      m_reg_write     <= 1'b0;
      m_mem_read      <= 1'b0;
      m_mem_write     <= 1'b0;
      m_mem_to_reg    <= 1'b0;
      m_branch_taken  <= 1'b0;
      m_alu_out       <= '0;
      m_rs2_data      <= '0;
      m_branch_target <= '0;
      m_rd            <= '0;
      taken_count     <= '0;
    end else if (flush) begin
      // bubble: controls cleared, data fields left as they were
      m_valid        <= 1'b0;
      m_reg_write    <= 1'b0;
      m_mem_read     <= 1'b0;
      m_mem_write    <= 1'b0;
      m_mem_to_reg   <= 1'b0;
      m_branch_taken <= 1'b0;
    end else if (!stall) begin
      m_valid         <= valid_in;
      m_reg_write     <= reg_write & valid_in;
      m_mem_read      <= mem_read & valid_in;
      m_mem_write     <= mem_write & valid_in;
      m_mem_to_reg    <= mem_to_reg;
      m_branch_taken  <= take;
      m_alu_out       <= alu_out;
      m_rs2_data      <= rs2_data;
      m_branch_target <= pc_target;
      m_rd            <= rd;
      if (take) taken_count <= count_cur + 32'd1;
    end
  end

endmodule

// File: tb/tb_ex_mem_reg.sv
// Directed plus randomized checks of ex_mem_reg against an operand-level model.
module tb_ex_mem_reg;

  logic        clk = 1'b0;
  logic        rst, stall, flush, valid_in;
  logic [31:0] alu_out, rs2_data, pc_target;
  logic        z, c, v;
  logic [4:0]  rd;
  logic [2:0]  funct3;
  logic        is_branch, reg_write, mem_read, mem_write, mem_to_reg;
  logic        m_valid, m_reg_write, m_mem_read, m_mem_write, m_mem_to_reg;
  logic [31:0] m_alu_out, m_rs2_data, m_branch_target;
  logic [4:0]  m_rd;
  logic        m_branch_taken;
  logic [31:0] taken_count;

  // condition the current stimulus should produce, set by the generators
  logic        cond_exp;

  logic        e_valid, e_rw, e_mr, e_mw, e_m2r, e_taken;
  logic [31:0] e_alu, e_rs2, e_tgt, e_cnt;
  logic [4:0]  e_rd;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  ex_mem_reg dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush), .valid_in(valid_in),
    .alu_out(alu_out), .z(z), .c(c), .v(v), .rs2_data(rs2_data), .rd(rd),
    .funct3(funct3), .is_branch(is_branch), .reg_write(reg_write),
    .mem_read(mem_read), .mem_write(mem_write), .mem_to_reg(mem_to_reg),
    .pc_target(pc_target), .m_valid(m_valid), .m_reg_write(m_reg_write),
    .m_mem_read(m_mem_read), .m_mem_write(m_mem_write),
    .m_mem_to_reg(m_mem_to_reg), .m_alu_out(m_alu_out),
    .m_rs2_data(m_rs2_data), .m_branch_target(m_branch_target), .m_rd(m_rd),
    .m_branch_taken(m_branch_taken), .taken_count(taken_count)
  );

  // Flags and expected branch outcome derived from a real subtraction a-b.
  task automatic from_ops(input logic [31:0] a, input logic [31:0] b);
    alu_out = a - b;
    z = (a == b);
    c = (a >= b);
    v = (a[31] != b[31]) && (alu_out[31] != a[31]);
    case (funct3)
      3'b000:  cond_exp = (a == b);
      3'b001:  cond_exp = (a != b);
      3'b100:  cond_exp = ($signed(a) < $signed(b));
      3'b101:  cond_exp = ($signed(a) >= $signed(b));
      3'b110:  cond_exp = (a < b);
      3'b111:  cond_exp = (a >= b);
      default: cond_exp = 1'b0;
    endcase
  endtask

  task automatic rand_vec();
    logic [31:0] a, b;
    valid_in   = ($urandom_range(0, 3) != 0);
    is_branch  = $urandom_range(0, 1);
    reg_write  = $urandom_range(0, 1);
    mem_read   = $urandom_range(0, 1);
    mem_write  = $urandom_range(0, 1);
    mem_to_reg = $urandom_range(0, 1);
    funct3     = 3'($urandom_range(0, 7));
    rd         = 5'($urandom_range(0, 31));
    rs2_data   = $urandom;
    pc_target  = $urandom;
    a = $urandom;
    case ($urandom_range(0, 3))
      0:       b = a;
      1:       b = a ^ 32'h8000_0000;
      default: b = $urandom;
    endcase
    from_ops(a, b);
  endtask

  task automatic set_flags(input logic [31:0] alu, input logic zz, input logic cc,
                           input logic vv, input logic [2:0] f3, input logic cnd);
    alu_out = alu; z = zz; c = cc; v = vv; funct3 = f3; cond_exp = cnd;
    is_branch = 1'b1; valid_in = 1'b1;
  endtask

  task automatic model_edge();
    logic take;
    take = is_branch & valid_in & cond_exp;
    if (rst) begin
      {e_valid, e_rw, e_mr, e_mw, e_m2r, e_taken} = '0;
      e_alu = '0; e_rs2 = '0; e_tgt = '0; e_rd = '0; e_cnt = '0;
    end else if (flush) begin
      {e_valid, e_rw, e_mr, e_mw, e_m2r, e_taken} = '0;
    end else if (!stall) begin
      e_valid = valid_in;
      e_rw    = valid_in & reg_write;
      e_mr    = valid_in & mem_read;
      e_mw    = valid_in & mem_write;
      e_m2r   = mem_to_reg;
      e_taken = take;
      e_alu   = alu_out;
      e_rs2   = rs2_data;
      e_tgt   = pc_target;
      e_rd    = rd;
      if (take) e_cnt = e_cnt + 32'd1;
    end
  endtask

  task automatic check(input string tag);
    logic [5:0]   ctl_o, ctl_e;
    logic [100:0] dat_o, dat_e;
    ctl_o = {m_valid, m_reg_write, m_mem_read, m_mem_write, m_mem_to_reg, m_branch_taken};
    ctl_e = {e_valid, e_rw, e_mr, e_mw, e_m2r, e_taken};
    dat_o = {m_alu_out, m_rs2_data, m_branch_target, m_rd};
    dat_e = {e_alu, e_rs2, e_tgt, e_rd};
    assert (ctl_o === ctl_e) else begin
      miscompares++;
      $error("FAIL %s ctrl: observed %b expected %b", tag, ctl_o, ctl_e);
    end
    assert (dat_o === dat_e) else begin
      miscompares++;
      $error("FAIL %s data: observed %h expected %h", tag, dat_o, dat_e);
    end
    assert (taken_count === e_cnt) else begin
      miscompares++;
      $error("FAIL %s taken_count: observed %h expected %h", tag, taken_count, e_cnt);
    end
  endtask

  // Inputs are driven after a negedge; step samples the edge and checks at +1.
  task automatic step(input string tag);
    @(posedge clk);
    model_edge();
    vectors++;
    #1 check(tag);
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1; stall = 1'b0; flush = 1'b0;
    rand_vec();
    e_cnt = 32'hDEAD_BEEF;
    @(negedge clk);
    step("reset0");
    step("reset1");
    rst = 1'b0;

    // 2000000000 - 2000000000, BEQ
    rand_vec();
    set_flags(32'h0, 1'b1, 1'b1, 1'b0, 3'b000, 1'b1);
    step("beq_taken");
    assert (m_branch_taken === 1'b1 && taken_count === 32'd1) else begin
      miscompares++;
      $error("FAIL beq_abs: observed %b/%0d expected 1/1", m_branch_taken, taken_count);
    end

    // -1 - 1
    set_flags(32'hFFFF_FFFE, 1'b0, 1'b1, 1'b0, 3'b100, 1'b1);
    step("blt_neg_taken");
    set_flags(32'hFFFF_FFFE, 1'b0, 1'b1, 1'b0, 3'b110, 1'b0);
    step("bltu_not_taken");
    // 0x80000000 - 1, signed overflow
    set_flags(32'h7FFF_FFFF, 1'b0, 1'b1, 1'b1, 3'b100, 1'b1);
    step("blt_ovf_taken");
    set_flags(32'h7FFF_FFFF, 1'b0, 1'b1, 1'b1, 3'b101, 1'b0);
    step("bge_ovf_not_taken");
    assert (taken_count === 32'd3) else begin
      miscompares++;
      $error("FAIL count_after_directed: observed %0d expected 3", taken_count);
    end

    // stall freeze, then flush+stall bubble
    rand_vec(); valid_in = 1'b1; reg_write = 1'b1; is_branch = 1'b1;
    funct3 = 3'b000; from_ops(32'd7, 32'd7);
    step("pre_stall_load");
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      rand_vec(); is_branch = 1'b1; valid_in = 1'b1;
      step("stall_hold");
    end
    flush = 1'b1;
    rand_vec();
    step("flush_stall");
    flush = 1'b0; stall = 1'b0;

    // randomized traffic
    for (int i = 0; i < 300; i++) begin
      rand_vec();
      stall = ($urandom_range(0, 9) == 0);
      flush = ($urandom_range(0, 9) == 0);
      rst   = ($urandom_range(0, 49) == 0);
      step("random");
    end
    rst = 1'b0; stall = 1'b0; flush = 1'b0;

    // counter wrap via override of the value the incrementer sees
    force dut.count_cur = 32'hFFFF_FFFF;
    e_cnt = 32'hFFFF_FFFF;
    rand_vec();
    set_flags(32'h0, 1'b1, 1'b1, 1'b0, 3'b000, 1'b1);
    step("count_wrap");
    release dut.count_cur;
    rand_vec();
    set_flags(32'h0, 1'b1, 1'b1, 1'b0, 3'b001, 1'b0);
    step("post_wrap");

    // reset during a stalled valid store
    rand_vec(); valid_in = 1'b1; mem_write = 1'b1;
    step("store_load");
    stall = 1'b1;
    rand_vec(); valid_in = 1'b1; mem_write = 1'b1;
    step("store_stalled");
    rst = 1'b1;
    step("rst_in_stall");
    rst = 1'b0; stall = 1'b0;
    rand_vec(); valid_in = 1'b1; reg_write = 1'b1; rd = 5'd0;
    step("post_rst_load");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/ex_mem_reg.md
EX_MEM_REG -- requirements
Module: ex_mem_reg

Interface
REQ-001 Parameter XLEN, default 32, datapath width.
REQ-002 Parameter RD_W, default 5, destination register index width.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 stall  input  1  hold all registered outputs.
REQ-006 flush  input  1  replace the captured entry with a bubble.
REQ-007 valid_in  input  1  EX stage holds a real instruction.
REQ-008 alu_out  input  XLEN  ALU result.
REQ-009 z, c, v  input  1 each  ALU zero, carry, overflow flags; c=1 means no borrow on subtract.
REQ-010 rs2_data  input  XLEN  store data.
REQ-011 rd  input  RD_W  destination index.
REQ-012 funct3  input  3  branch condition code.
REQ-013 is_branch, reg_write, mem_read, mem_write, mem_to_reg  input  1 each  control bits.
REQ-014 pc_target  input  XLEN  computed branch target.
REQ-015 m_valid, m_reg_write, m_mem_read, m_mem_write, m_mem_to_reg  output  1 each  registered control.
REQ-016 m_alu_out, m_rs2_data, m_branch_target  output  XLEN  registered data.
REQ-017 m_rd  output  RD_W  registered destination.
REQ-018 m_branch_taken  output  1  registered branch decision.
REQ-019 taken_count  output  32  count of taken branches since reset.

Function
REQ-020 Branch condition from flags, with n = alu_out[XLEN-1]: 000 BEQ z; 001 BNE !z; 100 BLT n^v; 101 BGE !(n^v); 110 BLTU !c; 111 BGEU c; 010/011 false.
REQ-021 take = is_branch & valid_in & condition; computed combinationally, registered in the same cycle as the data.
REQ-022 Latency: exactly one cycle from inputs to all m_* outputs.
REQ-023 Priority per edge: rst > flush > stall > load.
REQ-024 Load (no rst/flush/stall): every m_* output captures its input; m_branch_taken captures take.
REQ-025 Stall: all m_* outputs and taken_count hold their values.
REQ-026 Flush: m_valid, m_reg_write, m_mem_read, m_mem_write, m_mem_to_reg, m_branch_taken cleared to 0; data fields hold.
REQ-027 Flush and stall asserted together: flush wins; a bubble is inserted.
REQ-028 valid_in=0 on load: side-effect controls (m_reg_write, m_mem_write, m_mem_read) and m_branch_taken are forced to 0 regardless of inputs.
REQ-029 taken_count increments by 1 on a load edge where take=1; it wraps 0xFFFFFFFF -> 0; it does not increment on stall, flush or rst edges.
REQ-030 Writes with rd=0 pass through unchanged; suppression is the register file's job.

Reset
REQ-031 On rst edge: all m_* outputs and taken_count become 0, regardless of stall/flush.
REQ-032 rst mid-stall discards the held entry; the first post-reset load captures normally.

Structure
REQ-033 Shared package cpu_pkg holds XLEN, RD_W and branch funct3 constants (BEQ, BNE, BLT, BGE, BLTU, BGEU).
REQ-034 One sub-module, branch_cond: purely combinational funct3 + flags -> condition.

Verification
REQ-035 Bench drives alu_out=0, z=1, c=1, v=0 (2000000000 - 2000000000), funct3=000, is_branch=1, valid_in=1 -> next cycle m_branch_taken=1, taken_count=1.
REQ-036 Bench drives alu_out=0xFFFFFFFE, z=0, c=1, v=0 (-1 - 1): funct3=100 -> taken; funct3=110 -> not taken.
REQ-037 Bench drives alu_out=0x7FFFFFFF, v=1, c=1 (0x80000000 - 1), funct3=100 -> taken (n^v=1); funct3=101 -> not taken.
REQ-038 Bench asserts stall for 3 cycles while inputs change -> outputs and taken_count frozen; then flush+stall together -> m_valid=0, m_reg_write=0, m_branch_taken=0.
REQ-039 Bench forces taken_count to 0xFFFFFFFF via 2^32 preload or a bench-only force, then one taken branch -> taken_count=0.
REQ-040 Bench asserts rst during a stalled valid store -> all outputs 0 next cycle; a load on the following cycle captures new inputs.
